// File: rtl/vsync.sv
// Vertical timing for 640x480@60: line counter, vsync/vblank decode, maze cell-row index.
// Latency: decodes valid the cycle after the i_NewLine edge; optional frame counter under FRAME_CNT_EN.
module vsync #(
  parameter logic [9:0] V_LIMIT      = 10'd480,
  parameter logic [9:0] V_SYNC_START = 10'd490,
  parameter logic [9:0] V_SYNC_END   = 10'd492,
  parameter logic [9:0] V_TOTAL      = 10'd525
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_NewLine,
  input  logic [5:0] i_PixelSize,
  output logic       vsync_out,
  output logic       vblank,
  output logic [9:0] vPos,
  output logic [5:0] yPos,
  output logic       vDrawDone,
  output logic       frame_start,
  output logic [7:0] o_FrameCnt
);

  logic [9:0] vCnt;
  logic [9:0] nextV;
  logic [5:0] rowCnt;
  logic [5:0] sizeLat;
  logic       lastLine;
  logic       nextBlank;
  logic       wrapStep;

  assign lastLine  = (vCnt == V_TOTAL - 10'd1);
  assign nextV     = lastLine ? 10'd0 : vCnt + 10'd1;
  assign nextBlank = (nextV >= V_LIMIT);
  assign wrapStep  = i_NewLine & lastLine;

  assign vPos      = vCnt;
  assign vblank    = (vCnt >= V_LIMIT);
  assign vsync_out = ~((vCnt >= V_SYNC_START) && (vCnt < V_SYNC_END));
  assign vDrawDone = (vCnt == V_LIMIT - 10'd1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vCnt        <= 10'd0;
      rowCnt      <= 6'd0;
      yPos        <= 6'd0;
      sizeLat     <= 6'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrapStep;
      if (i_NewLine) begin
        vCnt <= nextV;
        // Cell size only changes at the frame boundary so a frame never tears.
        if (lastLine)
          sizeLat <= i_PixelSize;
        // The wrap step also clears so row 0 always begins on line 0.
        if (nextBlank || lastLine) begin
          rowCnt <= 6'd0;
          yPos   <= 6'd0;
        end else if (rowCnt == sizeLat) begin
          rowCnt <= 6'd0;
          if (yPos != 6'd63)
            yPos <= yPos + 6'd1;
        end else begin
          rowCnt <= rowCnt + 6'd1;
        end
      end
    end
  end

`ifdef FRAME_CNT_EN
  logic [7:0] frameCnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      frameCnt <= 8'd0;
    else if (wrapStep)
      frameCnt <= frameCnt + 8'd1;
  end

  assign o_FrameCnt = frameCnt;
`else
  assign o_FrameCnt = 8'd0;
`endif

endmodule

// File: tb/tb_vsync.sv
// Directed bench for vsync: frame timing, cell rows, size latching, frame pulse, resets.
module tb_vsync;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       i_NewLine;
  logic [5:0] i_PixelSize;
  logic       vsync_out;
  logic       vblank;
  logic [9:0] vPos;
  logic [5:0] yPos;
  logic       vDrawDone;
  logic       frame_start;
  logic [7:0] o_FrameCnt;

  int         errors = 0;
  int         checks = 0;
  int         expLine = 0;
  logic [7:0] expFrames = 8'd0;
  logic       lastWrap = 1'b0;

  vsync dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_NewLine  (i_NewLine),
    .i_PixelSize(i_PixelSize),
    .vsync_out  (vsync_out),
    .vblank     (vblank),
    .vPos       (vPos),
    .yPos       (yPos),
    .vDrawDone  (vDrawDone),
    .frame_start(frame_start),
    .o_FrameCnt (o_FrameCnt)
  );

  always #5 Clk = ~Clk;

  // Expected cell row for line l with cell height s+1.
  function automatic int expY(int l, int s);
    int r;
    if (l >= 480) return 0;
    r = l / (s + 1);
    return (r > 63) ? 63 : r;
  endfunction

  function automatic logic [7:0] expCnt();
`ifdef FRAME_CNT_EN
    return expFrames;
`else
    return 8'd0;
`endif
  endfunction

  // One line step; outputs are sampled on the falling edge after the stepping edge.
  task automatic stepLine();
    @(negedge Clk);
    i_NewLine = 1'b1;
    @(negedge Clk);
    i_NewLine = 1'b0;
    lastWrap = (expLine == 524);
    expLine  = lastWrap ? 0 : expLine + 1;
    if (lastWrap) expFrames = expFrames + 8'd1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    i_NewLine = 1'b0;
    i_PixelSize = 6'd0;
    repeat (2) @(negedge Clk);
    i_NewLine = 1'b1;
    repeat (3) @(negedge Clk);
    i_NewLine = 1'b0;
    checks++; if (vPos !== 10'd0) begin errors++; $display("FAIL reset_vPos: got %0d want 0", vPos); end
    checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL reset_vblank: got %b want 0", vblank); end
    checks++; if (vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync_out); end
    checks++; if (vDrawDone !== 1'b0) begin errors++; $display("FAIL reset_drawdone: got %b want 0", vDrawDone); end
    checks++; if (yPos !== 6'd0) begin errors++; $display("FAIL reset_yPos: got %0d want 0", yPos); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    checks++; if (o_FrameCnt !== 8'd0) begin errors++; $display("FAIL reset_framecnt: got %0d want 0", o_FrameCnt); end
    @(negedge Clk);
    Rst = 1'b1;
    expLine = 0;
    expFrames = 8'd0;
  endtask

  // First frame after reset: latched size is 0, so one-line cells saturating at 63.
  task automatic test_frame_timing();
    for (int i = 0; i < 525; i++) begin
      stepLine();
      checks++; if (vPos !== 10'(expLine)) begin errors++; $display("FAIL timing_vPos: got %0d want %0d", vPos, expLine); end
      checks++; if (vblank !== (expLine >= 480)) begin errors++; $display("FAIL timing_vblank line %0d: got %b", expLine, vblank); end
      checks++; if (vsync_out !== !(expLine == 490 || expLine == 491)) begin errors++; $display("FAIL timing_vsync line %0d: got %b", expLine, vsync_out); end
      checks++; if (vDrawDone !== (expLine == 479)) begin errors++; $display("FAIL timing_drawdone line %0d: got %b", expLine, vDrawDone); end
      checks++; if (frame_start !== lastWrap) begin errors++; $display("FAIL timing_frame_start line %0d: got %b want %b", expLine, frame_start, lastWrap); end
      checks++; if (yPos !== 6'(expY(expLine, 0))) begin errors++; $display("FAIL size0_yPos line %0d: got %0d want %0d", expLine, yPos, expY(expLine, 0)); end
    end
    checks++; if (vPos !== 10'd0) begin errors++; $display("FAIL timing_wrap: got %0d want 0", vPos); end
  endtask

  // Size 15 requested in a size-0 frame applies only from the next frame.
  task automatic test_size15();
    i_PixelSize = 6'd15;
    for (int i = 0; i < 525; i++) begin
      stepLine();
      if (expLine != 0) begin
        checks++; if (yPos !== 6'(expY(expLine, 0))) begin errors++; $display("FAIL size15_pending line %0d: got %0d want %0d", expLine, yPos, expY(expLine, 0)); end
      end
    end
    for (int i = 0; i < 200; i++) begin
      stepLine();
      checks++; if (yPos !== 6'(expY(expLine, 15))) begin errors++; $display("FAIL size15_yPos line %0d: got %0d want %0d", expLine, yPos, expY(expLine, 15)); end
    end
    checks++; if (vPos !== 10'd200) begin errors++; $display("FAIL size15_line: got %0d want 200", vPos); end
  endtask

  task automatic test_midframe_change();
    i_PixelSize = 6'd7;
    while (expLine != 0) begin
      stepLine();
      checks++; if (yPos !== 6'(expY(expLine, 15))) begin errors++; $display("FAIL midframe_keep line %0d: got %0d want %0d", expLine, yPos, expY(expLine, 15)); end
      if (expLine == 479) begin
        checks++; if (yPos !== 6'd29) begin errors++; $display("FAIL size15_last_row: got %0d want 29", yPos); end
      end
      if (expLine == 480) begin
        checks++; if (yPos !== 6'd0) begin errors++; $display("FAIL size15_blank_row: got %0d want 0", yPos); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      stepLine();
      checks++; if (yPos !== 6'(expY(expLine, 7))) begin errors++; $display("FAIL size7_yPos line %0d: got %0d want %0d", expLine, yPos, expY(expLine, 7)); end
      if (expLine == 8) begin
        checks++; if (yPos !== 6'd1) begin errors++; $display("FAIL size7_line8: got %0d want 1", yPos); end
      end
    end
  endtask

  task automatic test_frame_start();
    for (int i = 0; i < 525 && expLine != 524; i++) stepLine();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_before: got %b want 0", frame_start); end
    stepLine();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_pulse: got %b want 1", frame_start); end
    checks++; if (vPos !== 10'd0) begin errors++; $display("FAIL fs_vPos: got %0d want 0", vPos); end
    checks++; if (o_FrameCnt !== expCnt()) begin errors++; $display("FAIL fs_framecnt: got %0d want %0d", o_FrameCnt, expCnt()); end
    @(negedge Clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_one_cycle: got %b want 0", frame_start); end
    @(negedge Clk);
    checks++; if (o_FrameCnt !== expCnt()) begin errors++; $display("FAIL fs_framecnt_hold: got %0d want %0d", o_FrameCnt, expCnt()); end
  endtask

  task automatic test_held_newline();
    @(negedge Clk);
    i_NewLine = 1'b1;
    repeat (3) @(negedge Clk);
    i_NewLine = 1'b0;
    expLine = expLine + 3;
    checks++; if (vPos !== 10'd3) begin errors++; $display("FAIL held_vPos: got %0d want 3", vPos); end
    checks++; if (yPos !== 6'd0) begin errors++; $display("FAIL held_yPos: got %0d want 0", yPos); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL held_frame_start: got %b want 0", frame_start); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 525 && expLine != 300; i++) stepLine();
    checks++; if (yPos !== 6'd37) begin errors++; $display("FAIL pre_reset_yPos: got %0d want 37", yPos); end
    @(negedge Clk);
    #2 Rst = 1'b0;
    i_PixelSize = 6'd15;
    #1;
    checks++; if (vPos !== 10'd0) begin errors++; $display("FAIL areset_vPos: got %0d want 0", vPos); end
    checks++; if (yPos !== 6'd0) begin errors++; $display("FAIL areset_yPos: got %0d want 0", yPos); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL areset_frame_start: got %b want 0", frame_start); end
    checks++; if (o_FrameCnt !== 8'd0) begin errors++; $display("FAIL areset_framecnt: got %0d want 0", o_FrameCnt); end
    checks++; if (vsync_out !== 1'b1 || vblank !== 1'b0 || vDrawDone !== 1'b0) begin
      errors++; $display("FAIL areset_decodes: vsync=%b vblank=%b drawdone=%b want 1/0/0", vsync_out, vblank, vDrawDone);
    end
    @(negedge Clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL areset_no_pulse: got %b want 0", frame_start); end
    Rst = 1'b1;
    expLine = 0;
    expFrames = 8'd0;
    stepLine();
    checks++; if (vPos !== 10'd1) begin errors++; $display("FAIL resume_vPos: got %0d want 1", vPos); end
    checks++; if (yPos !== 6'd1) begin errors++; $display("FAIL resume_yPos: got %0d want 1", yPos); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL resume_frame_start: got %b want 0", frame_start); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_size15();
    test_midframe_change();
    test_frame_start();
    test_held_newline();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
